// File: rtl/control_sequencer_pkg.sv
// Shared encodings for the control sequencer and any datapath bench built on it.
// Opcodes, FSM states and the per-cycle control word live here.
package control_sequencer_pkg;

  localparam int IMM_W = 8;
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    OP_LDIA = 2'b00,
    OP_ADDI = 2'b01,
    OP_MVBZ = 2'b10,
    OP_NOP  = 2'b11
  } opcode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_T0   = 2'b01,
    ST_T1   = 2'b10,
    ST_DONE = 2'b11
  } state_t;

  // One cycle's worth of register-transfer controls.
  typedef struct packed {
    logic             ra_in;
    logic             rb_in;
    logic             rz_in;
    logic             ra_out;
    logic             rb_out;
    logic             rz_out;
    logic [IMM_W-1:0] ra_imm;
    logic [IMM_W-1:0] add_imm;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '0;

  function automatic logic is_ldia(input opcode_t op);
    return op == OP_LDIA;
  endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Bundle of instruction-issue and control-output signals of the sequencer.
// Issue handshake: start is taken only while busy=0; busy=1 means not ready and start is ignored.
interface control_sequencer_if;
  import control_sequencer_pkg::*;

  logic                 start;
  logic [1:0]           opcode;
  logic [IMM_W-1:0]     imm;

  logic [IMM_W-1:0]     RegisterAImmediate;
  logic [IMM_W-1:0]     AddImmediate;
  logic                 RAin;
  logic                 RBin;
  logic                 RZin;
  logic                 RAout;
  logic                 RBout;
  logic                 RZout;
  logic                 busy;
  logic                 done;
  logic [CNT_W-1:0]     instr_count;
  state_t               state_dbg;

  modport master (
    output start, opcode, imm,
    input  RegisterAImmediate, AddImmediate,
    input  RAin, RBin, RZin, RAout, RBout, RZout,
    input  busy, done, instr_count, state_dbg
  );

  modport slave (
    input  start, opcode, imm,
    output RegisterAImmediate, AddImmediate,
    output RAin, RBin, RZin, RAout, RBout, RZout,
    output busy, done, instr_count, state_dbg
  );

endinterface

// File: rtl/control_sequencer.sv
// Four-state instruction sequencer: captures an opcode/immediate in IDLE and
// walks T0/T1/DONE issuing register load and bus drive enables.
module control_sequencer
  import control_sequencer_pkg::*;
(
  input logic                clock,
  input logic                clear,
  control_sequencer_if.slave bus
);

  state_t             r_state;
  opcode_t            r_opcode;
  logic [IMM_W-1:0]   r_imm;
  logic [CNT_W-1:0]   r_count;

  state_t             w_next_state;
  ctrl_t              w_ctrl;
  logic               w_accept;

  assign w_accept = (r_state == ST_IDLE) && bus.start;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Captured fields only move on acceptance, so they stay stable for the whole instruction.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_opcode <= OP_LDIA;
      r_imm    <= '0;
    end else if (w_accept) begin
      r_opcode <= opcode_t'(bus.opcode);
      r_imm    <= bus.imm;
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_count <= '0;
    end else if (r_state == ST_DONE) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  always_comb begin
    w_next_state = ST_IDLE;
    w_ctrl       = CTRL_NONE;
    casez ({r_state, r_opcode})
      {ST_IDLE, 2'b??}: begin
        w_next_state = bus.start ? ST_T0 : ST_IDLE;
      end
      {ST_T0, OP_LDIA}: begin
        w_ctrl.ra_in  = 1'b1;
        w_ctrl.ra_imm = r_imm;
        w_next_state  = ST_DONE;
      end
      {ST_T0, OP_ADDI}: begin
        w_ctrl.ra_out  = 1'b1;
        w_ctrl.rz_in   = 1'b1;
        w_ctrl.add_imm = r_imm;
        w_next_state   = ST_T1;
      end
      {ST_T0, OP_MVBZ}: begin
        w_ctrl.rz_out = 1'b1;
        w_ctrl.rb_in  = 1'b1;
        w_next_state  = ST_DONE;
      end
      {ST_T0, OP_NOP}: begin
        w_next_state = ST_DONE;
      end
      {ST_T1, OP_ADDI}: begin
        w_ctrl.rz_out = 1'b1;
        w_ctrl.rb_in  = 1'b1;
        w_next_state  = ST_DONE;
      end
      {ST_DONE, 2'b??}: begin
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
        w_ctrl       = CTRL_NONE;
      end
    endcase
  end

  assign bus.RAin               = w_ctrl.ra_in;
  assign bus.RBin               = w_ctrl.rb_in;
  assign bus.RZin               = w_ctrl.rz_in;
  assign bus.RAout              = w_ctrl.ra_out;
  assign bus.RBout              = w_ctrl.rb_out;
  assign bus.RZout              = w_ctrl.rz_out;
  assign bus.RegisterAImmediate = w_ctrl.ra_imm;
  assign bus.AddImmediate       = w_ctrl.add_imm;
  assign bus.busy               = (r_state != ST_IDLE);
  assign bus.done               = (r_state == ST_DONE);
  assign bus.instr_count        = r_count;
  assign bus.state_dbg          = r_state;

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized and directed bench for control_sequencer against a transaction-level
// model that expands each accepted instruction into its expected per-cycle controls.
module tb_control_sequencer;
  import control_sequencer_pkg::*;

  logic clock;
  logic clear;

  control_sequencer_if bus();

  control_sequencer dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int unsigned n_cmp  = 0;
  int unsigned n_err  = 0;
  int unsigned n_done = 0;

  // Expected per-cycle control vectors; empty means the sequencer should be idle.
  logic [23:0] exp_q[$];
  logic [7:0]  m_count = 8'h00;

  logic [23:0] dut_vec;
  assign dut_vec = {bus.busy, bus.done, bus.RAin, bus.RBin, bus.RZin,
                    bus.RAout, bus.RBout, bus.RZout,
                    bus.RegisterAImmediate, bus.AddImmediate};

  // Small register-transfer datapath driven by the sequencer's enables.
  logic [7:0] dp_a = 8'h00;
  logic [7:0] dp_b = 8'h00;
  logic [7:0] dp_z = 8'h00;
  logic [7:0] dp_bus;
  assign dp_bus = bus.RAout ? dp_a : (bus.RZout ? dp_z : 8'h00);

  always @(posedge clock) begin
    if (bus.RAin) dp_a <= bus.RegisterAImmediate;
    if (bus.RZin) dp_z <= dp_bus + bus.AddImmediate;
    if (bus.RBin) dp_b <= dp_bus;
  end

  always @(negedge clock) begin
    assert ($onehot0({bus.RAout, bus.RBout, bus.RZout}))
      else $error("FAIL onehot_out: RAout=%b RBout=%b RZout=%b", bus.RAout, bus.RBout, bus.RZout);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [23:0] vec(input logic bsy, input logic dn,
                                      input logic rai, input logic rbi, input logic rzi,
                                      input logic rao, input logic rbo, input logic rzo,
                                      input logic [7:0] raimm, input logic [7:0] addimm);
    return {bsy, dn, rai, rbi, rzi, rao, rbo, rzo, raimm, addimm};
  endfunction

  task automatic push_instr(input logic [1:0] op, input logic [7:0] im);
    case (op)
      2'b00: exp_q.push_back(vec(1, 0, 1, 0, 0, 0, 0, 0, im, 8'h00));
      2'b01: begin
        exp_q.push_back(vec(1, 0, 0, 0, 1, 1, 0, 0, 8'h00, im));
        exp_q.push_back(vec(1, 0, 0, 1, 0, 0, 0, 1, 8'h00, 8'h00));
      end
      2'b10: exp_q.push_back(vec(1, 0, 0, 1, 0, 0, 0, 1, 8'h00, 8'h00));
      default: exp_q.push_back(vec(1, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00));
    endcase
    exp_q.push_back(vec(1, 1, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00));
  endtask

  // Check the current cycle, then drive inputs for the next rising edge and advance the model.
  task automatic cycle(input logic s, input logic [1:0] op, input logic [7:0] im);
    logic [23:0] cur;
    @(negedge clock);
    cur = (exp_q.size() == 0) ? 24'h000000 : exp_q[0];
    check("controls", {8'h00, dut_vec}, {8'h00, cur});
    check("instr_count", {24'h000000, bus.instr_count}, {24'h000000, m_count});
    if (bus.done) n_done++;
    bus.start  = s;
    bus.opcode = op;
    bus.imm    = im;
    if (exp_q.size() != 0) begin
      if (exp_q[0][22]) m_count = m_count + 8'd1;
      void'(exp_q.pop_front());
    end else if (s) begin
      push_instr(op, im);
    end
  endtask

  // Asynchronous clear asserted between edges; outputs must drop without waiting for a clock.
  task automatic pulse_clear();
    #2;
    bus.start = 1'b0;
    clear     = 1'b0;
    #1;
    exp_q.delete();
    m_count = 8'h00;
    check("clear_controls", {8'h00, dut_vec}, 32'h0);
    check("clear_count", {24'h000000, bus.instr_count}, 32'h0);
    @(posedge clock);
    #1;
    check("clear_hold_controls", {8'h00, dut_vec}, 32'h0);
    check("clear_hold_state", {30'h0, bus.state_dbg}, {30'h0, ST_IDLE});
    @(negedge clock);
    clear = 1'b1;
  endtask

  int unsigned done_before;

  initial begin
    clear      = 1'b0;
    bus.start  = 1'b0;
    bus.opcode = 2'b00;
    bus.imm    = 8'h00;
    #12;
    check("reset_controls", {8'h00, dut_vec}, 32'h0);
    check("reset_count", {24'h000000, bus.instr_count}, 32'h0);
    check("reset_state", {30'h0, bus.state_dbg}, {30'h0, ST_IDLE});
    @(negedge clock);
    clear = 1'b1;

    // LDIA 5 then ADDI 5: datapath must end with B = A + 5.
    cycle(1, 2'b00, 8'h05);
    cycle(0, 2'b00, 8'h00);
    cycle(0, 2'b00, 8'h00);
    cycle(1, 2'b01, 8'h05);
    cycle(0, 2'b00, 8'h00);
    cycle(0, 2'b00, 8'h00);
    cycle(0, 2'b00, 8'h00);
    cycle(0, 2'b00, 8'h00);
    check("dp_a", {24'h0, dp_a}, 32'h05);
    check("dp_z", {24'h0, dp_z}, 32'h0A);
    check("dp_b", {24'h0, dp_b}, 32'h0A);

    // start toggled with other opcodes while an ADDI runs: ignored.
    done_before = n_done;
    cycle(1, 2'b01, 8'h33);
    cycle(1, 2'b00, 8'h77);
    cycle(0, 2'b00, 8'h11);
    cycle(1, 2'b00, 8'h22);
    cycle(0, 2'b00, 8'h00);
    cycle(0, 2'b00, 8'h00);
    check("toggle_single_done", n_done - done_before, 32'd1);

    // Abort an ADDI in T1 from a zero count.
    pulse_clear();
    done_before = n_done;
    cycle(1, 2'b01, 8'h44);
    cycle(0, 2'b00, 8'h00);
    cycle(0, 2'b00, 8'h00);
    pulse_clear();
    cycle(0, 2'b00, 8'h00);
    cycle(0, 2'b00, 8'h00);
    check("abort_no_done", n_done - done_before, 32'd0);
    check("abort_count", {24'h0, bus.instr_count}, 32'h0);

    // 256 back-to-back NOPs with start held: count wraps back to zero.
    done_before = n_done;
    for (int i = 0; i < 768; i++) begin
      cycle(1, 2'b11, 8'($urandom_range(0, 255)));
    end
    cycle(0, 2'b11, 8'h00);
    check("nop_done_pulses", n_done - done_before, 32'd256);
    check("nop_count_wrap", {24'h0, bus.instr_count}, 32'h0);

    // Random mix of instructions and start patterns.
    for (int i = 0; i < 600; i++) begin
      cycle(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
    end
    for (int i = 0; i < 4; i++) begin
      cycle(0, 2'b00, 8'h00);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 clock  input  1  sole clock; all state changes on its rising edge.
REQ-002 clear  input  1  reset, asynchronous and active-low; 0 forces the reset state immediately.
REQ-003 start  input  1  request to execute one instruction; sampled only in IDLE.
REQ-004 opcode  input  2  instruction: 00 LDIA (A <- imm), 01 ADDI (B <- A + imm via Z), 10 MVBZ (B <- Z), 11 NOP.
REQ-005 imm  input  8  immediate operand, captured with start.
REQ-006 RegisterAImmediate  output  8  immediate value driven to register A load path.
REQ-007 AddImmediate  output  8  immediate value driven to adder second operand.
REQ-008 RAin, RBin, RZin  output  1 each  register load enables.
REQ-009 RAout, RBout, RZout  output  1 each  bus drive enables.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 done  output  1  one-cycle pulse marking instruction completion.
REQ-012 instr_count  output  8  count of completed instructions.

Function
REQ-013 The FSM SHALL have states IDLE, T0, T1, DONE.
REQ-014 IDLE with start=1 SHALL capture opcode and imm into internal registers and move to T0 on the next edge.
REQ-015 IDLE with start=0 SHALL remain in IDLE.
REQ-016 start SHALL be ignored outside IDLE; captured opcode/imm SHALL NOT change until the next acceptance.
REQ-017 T0 for LDIA: RAin=1, RegisterAImmediate=imm; next state DONE.
REQ-018 T0 for ADDI: RAout=1, AddImmediate=imm, RZin=1; next state T1.
REQ-019 T0 for MVBZ: RZout=1, RBin=1; next state DONE.
REQ-020 T0 for NOP: all enables 0; next state DONE.
REQ-021 T1 (ADDI only): RZout=1, RBin=1; next state DONE.
REQ-022 DONE: done=1, all enables 0, instr_count increments by 1; next state IDLE.
REQ-023 Outside the states listed above, all enables SHALL be 0 and both immediate outputs SHALL be 8'h00.
REQ-024 Control outputs SHALL derive only from the state register and captured fields; there is no combinational path from start, opcode or imm.
REQ-025 At most one of RAout, RBout, RZout SHALL be high in any cycle; RBout is reserved and always 0.
REQ-026 Latency from the start-accept edge to the done pulse:
- LDIA, MVBZ, NOP: 2 cycles.
- ADDI: 3 cycles.
REQ-027 instr_count SHALL wrap from 8'hFF to 8'h00.
REQ-028 Back-to-back execution: start held high SHALL be accepted in the IDLE cycle that follows DONE; the minimum issue interval is 3 cycles (4 for ADDI).

Reset
REQ-029 clear=0 SHALL asynchronously force:
- state IDLE;
- busy=0, done=0;
- all enables 0;
- RegisterAImmediate and AddImmediate 8'h00;
- instr_count 8'h00;
- captured opcode and imm 0.
REQ-030 clear asserted mid-instruction SHALL abort the instruction with no done pulse and no count increment.
REQ-031 After clear deasserts, the first possible acceptance is on the first rising edge with start=1.

Structure
REQ-032 Opcode encodings and the state encoding SHALL live in a shared package used by the datapath bench.
REQ-033 The block SHALL be a single module with no sub-modules; the enable decode is one case on {state, captured opcode}.

Verification
REQ-034 LDIA, imm=8'h05, start for one cycle -> one cycle later RAin=1 with RegisterAImmediate=8'h05; done pulses on the next cycle; instr_count=1.
REQ-035 ADDI, imm=8'h05, after LDIA 5 -> T0 has RAout, RZin, AddImmediate=8'h05; T1 has RZout, RBin; datapath B=8'h0A; done in the third cycle.
REQ-036 start toggled during T0/T1 of an ADDI with opcode=00 -> no extra instruction; captured imm unchanged; exactly one done.
REQ-037 clear pulsed low during T1 of an ADDI -> all outputs 0 immediately; no done; instr_count unchanged at 0.
REQ-038 256 NOP instructions with start held high -> done pulses every 3 cycles; instr_count returns to 8'h00; enables never asserted.
REQ-039 Every cycle of every test -> at most one *out enable high (assertion).
